// File: rtl/ant_scheduler_pkg.sv
// Shared constants, state/grant encodings and the clear-instruction packer
// used by the frame sequencer and its datapath mux.
package ant_scheduler_pkg;

  localparam int NUM_ANTS_DEFAULT = 16;
  localparam int SCREEN_WIDTH     = 160;
  localparam int SCREEN_HEIGHT    = 120;

  localparam int MEM_ADDR_WIDTH   = 8;
  localparam int X_COORD_WIDTH    = 8;
  localparam int Y_COORD_WIDTH    = 7;
  localparam int COLOUR_WIDTH     = 3;
  localparam int OPCODE_WIDTH     = 3;
  localparam int INSTRUCTION_WIDTH =
    1 + COLOUR_WIDTH + Y_COORD_WIDTH + X_COORD_WIDTH + OPCODE_WIDTH;

  localparam logic [COLOUR_WIDTH-1:0] COLOUR_BG   = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW = 3'd2;

  typedef enum logic [3:0] {
    SCHED_OP_IDLE       = 4'd0,
    SCHED_OP_CLR_START  = 4'd1,
    SCHED_OP_CLR_DELAY  = 4'd2,
    SCHED_OP_CLR_WAIT   = 4'd3,
    SCHED_OP_UPD_START  = 4'd4,
    SCHED_OP_UPD_DELAY  = 4'd5,
    SCHED_OP_UPD_WAIT   = 4'd6,
    SCHED_OP_DRAW_START = 4'd7,
    SCHED_OP_DRAW_DELAY = 4'd8,
    SCHED_OP_DRAW_WAIT  = 4'd9,
    SCHED_OP_DONE       = 4'd10
  } sched_state_t;

  typedef enum logic [1:0] {
    GRANT_SELF = 2'd0,
    GRANT_UPD  = 2'd1,
    GRANT_DRAW = 2'd2
  } grant_t;

  // Top bit marks a fill-style draw; colour, y, x, opcode follow.
  function automatic logic [INSTRUCTION_WIDTH-1:0] clear_instr(
    input logic [X_COORD_WIDTH-1:0] x,
    input logic [Y_COORD_WIDTH-1:0] y
  );
    return {1'b1, COLOUR_BG, y, x, OPCODE_DRAW};
  endfunction

endpackage

// File: rtl/ant_scheduler_dp_mux.sv
// Combinational 3-way selector for the single datapath instruction port.
import ant_scheduler_pkg::*;

module ant_dp_mux (
  input  grant_t                       grant,
  input  logic                         self_start_dp,
  input  logic [INSTRUCTION_WIDTH-1:0] self_instruction_dp,
  input  logic                         upd_start_dp,
  input  logic [INSTRUCTION_WIDTH-1:0] upd_instruction_dp,
  input  logic                         draw_start_dp,
  input  logic [INSTRUCTION_WIDTH-1:0] draw_instruction_dp,
  output logic                         start_dp,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

  always_comb begin
    start_dp       = self_start_dp;
    instruction_dp = self_instruction_dp;
    case (grant)
      GRANT_UPD: begin
        start_dp       = upd_start_dp;
        instruction_dp = upd_instruction_dp;
      end
      GRANT_DRAW: begin
        start_dp       = draw_start_dp;
        instruction_dp = draw_instruction_dp;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/ant_scheduler.sv
// Frame sequencer: optional screen clear, then update+draw for every ant id,
// arbitrating the shared datapath port between itself and the two clients.
import ant_scheduler_pkg::*;

module ant_scheduler #(
  parameter int NUM_ANTS = NUM_ANTS_DEFAULT,
  parameter int CLEAR_W  = SCREEN_WIDTH,
  parameter int CLEAR_H  = SCREEN_HEIGHT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         clear_en,
  output logic                         finished,
  output logic [15:0]                  frame_count,
  output logic [MEM_ADDR_WIDTH-1:0]    id,
  output logic                         upd_start,
  input  logic                         upd_finished,
  input  logic                         upd_start_dp,
  input  logic [INSTRUCTION_WIDTH-1:0] upd_instruction_dp,
  output logic                         draw_start,
  input  logic                         draw_finished,
  input  logic                         draw_start_dp,
  input  logic [INSTRUCTION_WIDTH-1:0] draw_instruction_dp,
  output logic                         start_dp,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
  input  logic                         finished_dp,
  output sched_state_t                 state_dbg
);

  // Handshakes: a frame request (start) is taken only while finished=1.
  // Each client and the datapath get a start level/pulse and are treated as
  // done on the first WAIT cycle that sees their finished input high; the
  // finished inputs are ignored in every other state.

  localparam logic [X_COORD_WIDTH-1:0]  CX_LAST = X_COORD_WIDTH'(CLEAR_W - 1);
  localparam logic [Y_COORD_WIDTH-1:0]  CY_LAST = Y_COORD_WIDTH'(CLEAR_H - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ID_LAST = MEM_ADDR_WIDTH'(NUM_ANTS - 1);

  sched_state_t                  state_q, state_d;
  grant_t                        grant_q, grant_d;
  logic [X_COORD_WIDTH-1:0]      cx_q, cx_d;
  logic [Y_COORD_WIDTH-1:0]      cy_q, cy_d;
  logic [MEM_ADDR_WIDTH-1:0]     id_d;
  logic                          finished_d;
  logic [15:0]                   frame_count_d;
  logic [INSTRUCTION_WIDTH-1:0]  instr_hold_q;
  logic                          self_start_dp;
  logic [INSTRUCTION_WIDTH-1:0]  self_instruction_dp;

  assign state_dbg = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SCHED_OP_IDLE;
      grant_q      <= GRANT_SELF;
      cx_q         <= '0;
      cy_q         <= '0;
      id           <= '0;
      finished     <= 1'b1;
      frame_count  <= '0;
      instr_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      id           <= id_d;
      finished     <= finished_d;
      frame_count  <= frame_count_d;
      instr_hold_q <= instruction_dp;
    end
  end

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    cx_d                = cx_q;
    cy_d                = cy_q;
    id_d                = id;
    finished_d          = finished;
    frame_count_d       = frame_count;
    self_start_dp       = 1'b0;
    self_instruction_dp = instr_hold_q;
    upd_start           = 1'b0;
    draw_start          = 1'b0;

    case (state_q)
      SCHED_OP_IDLE: begin
        if (start) begin
          cx_d       = '0;
          cy_d       = '0;
          id_d       = '0;
          finished_d = 1'b0;
          if (clear_en) begin
            state_d = SCHED_OP_CLR_START;
            grant_d = GRANT_SELF;
          end else begin
            state_d = SCHED_OP_UPD_START;
            grant_d = GRANT_UPD;
          end
        end
      end

      SCHED_OP_CLR_START, SCHED_OP_CLR_DELAY: begin
        self_start_dp       = 1'b1;
        self_instruction_dp = clear_instr(cx_q, cy_q);
        state_d = (state_q == SCHED_OP_CLR_START) ? SCHED_OP_CLR_DELAY
                                                  : SCHED_OP_CLR_WAIT;
      end

      SCHED_OP_CLR_WAIT: begin
        if (finished_dp) begin
          if (cx_q == CX_LAST) begin
            cx_d = '0;
            cy_d = cy_q + 1'b1;
            if (cy_q == CY_LAST) begin
              state_d = SCHED_OP_UPD_START;
              grant_d = GRANT_UPD;
            end else begin
              state_d = SCHED_OP_CLR_START;
            end
          end else begin
            cx_d    = cx_q + 1'b1;
            state_d = SCHED_OP_CLR_START;
          end
        end
      end

      SCHED_OP_UPD_START: begin
        upd_start = 1'b1;
        state_d   = SCHED_OP_UPD_DELAY;
      end

      // Gives the client a cycle to drop its finished flag.
      SCHED_OP_UPD_DELAY: state_d = SCHED_OP_UPD_WAIT;

      SCHED_OP_UPD_WAIT: begin
        if (upd_finished) begin
          state_d = SCHED_OP_DRAW_START;
          grant_d = GRANT_DRAW;
        end
      end

      SCHED_OP_DRAW_START: begin
        draw_start = 1'b1;
        state_d    = SCHED_OP_DRAW_DELAY;
      end

      SCHED_OP_DRAW_DELAY: state_d = SCHED_OP_DRAW_WAIT;

      SCHED_OP_DRAW_WAIT: begin
        if (draw_finished) begin
          if (id == ID_LAST) begin
            state_d = SCHED_OP_DONE;
            grant_d = GRANT_SELF;
          end else begin
            id_d    = id + 1'b1;
            state_d = SCHED_OP_UPD_START;
            grant_d = GRANT_UPD;
          end
        end
      end

      SCHED_OP_DONE: begin
        frame_count_d = frame_count + 16'd1;
        finished_d    = 1'b1;
        grant_d       = GRANT_SELF;
        state_d       = SCHED_OP_IDLE;
      end

      default: begin
        state_d = SCHED_OP_IDLE;
        grant_d = GRANT_SELF;
      end
    endcase
  end

  ant_dp_mux u_dp_mux (
    .grant               (grant_q),
    .self_start_dp       (self_start_dp),
    .self_instruction_dp (self_instruction_dp),
    .upd_start_dp        (upd_start_dp),
    .upd_instruction_dp  (upd_instruction_dp),
    .draw_start_dp       (draw_start_dp),
    .draw_instruction_dp (draw_instruction_dp),
    .start_dp            (start_dp),
    .instruction_dp      (instruction_dp)
  );

endmodule

// File: tb/tb_ant_scheduler.sv
// Scoreboarded bench for ant_scheduler with randomized datapath/client latencies.
`timescale 1ns/1ps
module tb_ant_scheduler;
  import ant_scheduler_pkg::*;

  localparam int NA = 3;
  localparam int CW = 4;
  localparam int CH = 2;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int W  = 40;
  localparam logic [3:0] K_CLR  = 4'd1;
  localparam logic [3:0] K_UPD  = 4'd2;
  localparam logic [3:0] K_DRAW = 4'd3;
  localparam logic [3:0] K_END  = 4'd4;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      start = 1'b0;
  logic                      clear_en = 1'b0;
  logic                      finished;
  logic [15:0]               frame_count;
  logic [MEM_ADDR_WIDTH-1:0] id;
  logic                      upd_start;
  logic                      upd_finished = 1'b1;
  logic                      upd_start_dp = 1'b0;
  logic [IW-1:0]             upd_instruction_dp = '0;
  logic                      draw_start;
  logic                      draw_finished = 1'b1;
  logic                      draw_start_dp = 1'b0;
  logic [IW-1:0]             draw_instruction_dp = '0;
  logic                      start_dp;
  logic [IW-1:0]             instruction_dp;
  logic                      finished_dp = 1'b1;
  sched_state_t              state_dbg;

  ant_scheduler #(.NUM_ANTS(NA), .CLEAR_W(CW), .CLEAR_H(CH)) u_dut (
    .clock(clock), .reset(reset), .start(start), .clear_en(clear_en),
    .finished(finished), .frame_count(frame_count), .id(id),
    .upd_start(upd_start), .upd_finished(upd_finished),
    .upd_start_dp(upd_start_dp), .upd_instruction_dp(upd_instruction_dp),
    .draw_start(draw_start), .draw_finished(draw_finished),
    .draw_start_dp(draw_start_dp), .draw_instruction_dp(draw_instruction_dp),
    .start_dp(start_dp), .instruction_dp(instruction_dp),
    .finished_dp(finished_dp), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int model_frames = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [35:0] p);
    return {k, p};
  endfunction

  task automatic pop_check(input string name, input logic [3:0] k, input logic [35:0] p);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got event %0h with nothing expected (t=%0t)", name, ev(k, p), $time);
    end else begin
      e = exp_q.pop_front();
      check(name, ev(k, p), e);
    end
  endtask

  // Reference model: the whole frame's observable event sequence.
  task automatic push_frame(input bit with_clear);
    logic [IW-1:0] ins;
    logic [X_COORD_WIDTH-1:0] xx;
    logic [Y_COORD_WIDTH-1:0] yy;
    if (with_clear) begin
      for (int y = 0; y < CH; y++) begin
        for (int x = 0; x < CW; x++) begin
          xx = X_COORD_WIDTH'(x);
          yy = Y_COORD_WIDTH'(y);
          ins = {1'b1, COLOUR_BG, yy, xx, OPCODE_DRAW};
          exp_q.push_back(ev(K_CLR, 36'(ins)));
        end
      end
    end
    for (int i = 0; i < NA; i++) begin
      exp_q.push_back(ev(K_UPD, 36'(i)));
      exp_q.push_back(ev(K_DRAW, 36'(i)));
    end
    model_frames = (model_frames + 1) % 65536;
    exp_q.push_back(ev(K_END, 36'(model_frames)));
  endtask

  // Monitor + datapath/client models, one process sampling 1ns after each edge.
  int  cyc = 0;
  int  dp_cnt = 0, upd_cnt = 0, draw_cnt = 0;
  int  lat;
  bit  prev_sdp = 1'b0, prev_fin = 1'b1, in_clients = 1'b0;
  bit  have_clr = 1'b0, have_draw = 1'b0;
  int  last_clr_cyc, last_upd_cyc = 0, last_draw_cyc;
  int  exp_clr_gap = 3, exp_gap_upd = 3, exp_gap_draw = 3;
  logic sdp_now;

  always @(posedge clock) begin
    #1;
    cyc++;
    if (reset) begin
      upd_finished = 1'b1; draw_finished = 1'b1; finished_dp = 1'b1;
      dp_cnt = 0; upd_cnt = 0; draw_cnt = 0;
      in_clients = 1'b0; have_clr = 1'b0; have_draw = 1'b0;
      prev_sdp = 1'b0; prev_fin = 1'b1;
    end else begin
      sdp_now = start_dp;
      if (upd_start) begin
        in_clients = 1'b1;
        pop_check("upd_id", K_UPD, 36'(id));
        if (have_draw) check("draw_to_upd_gap", 64'(cyc - last_draw_cyc), 64'(exp_gap_draw));
        have_draw = 1'b0;
        last_upd_cyc = cyc;
      end
      if (upd_start || upd_cnt > 0) begin
        check("upd_mux_start", start_dp, upd_start_dp);
        check("upd_mux_instr", instruction_dp, upd_instruction_dp);
      end
      if (draw_start) begin
        pop_check("draw_id", K_DRAW, 36'(id));
        check("upd_to_draw_gap", 64'(cyc - last_upd_cyc), 64'(exp_gap_upd));
        have_draw = 1'b1;
        last_draw_cyc = cyc;
      end
      if (draw_start || draw_cnt > 0) begin
        check("draw_mux_start", start_dp, draw_start_dp);
        check("draw_mux_instr", instruction_dp, draw_instruction_dp);
      end
      if (sdp_now && !prev_sdp && !in_clients && !finished) begin
        pop_check("clear_instr", K_CLR, 36'(instruction_dp));
        if (have_clr) check("clear_gap", 64'(cyc - last_clr_cyc), 64'(exp_clr_gap));
        have_clr = 1'b1;
        last_clr_cyc = cyc;
      end
      if (finished && !prev_fin) begin
        pop_check("frame_end", K_END, 36'(frame_count));
        if (have_draw) check("draw_to_end_gap", 64'(cyc - last_draw_cyc), 64'(exp_gap_draw + 1));
        in_clients = 1'b0; have_clr = 1'b0; have_draw = 1'b0;
      end

      // datapath model: finished_dp low for lat cycles after each start_dp rise
      if (sdp_now && !prev_sdp) begin
        lat = $urandom_range(2, 4);
        dp_cnt = lat;
        finished_dp = 1'b0;
        exp_clr_gap = 3 + ((lat > 2) ? lat - 2 : 0);
      end else if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) finished_dp = 1'b1;
      end

      // client stubs
      if (upd_start) begin
        lat = $urandom_range(2, 6);
        upd_cnt = lat;
        upd_finished = 1'b0;
        exp_gap_upd = 3 + ((lat > 2) ? lat - 2 : 0);
      end else if (upd_cnt > 0) begin
        upd_cnt--;
        if (upd_cnt == 0) upd_finished = 1'b1;
      end
      if (draw_start) begin
        lat = $urandom_range(2, 6);
        draw_cnt = lat;
        draw_finished = 1'b0;
        exp_gap_draw = 3 + ((lat > 2) ? lat - 2 : 0);
      end else if (draw_cnt > 0) begin
        draw_cnt--;
        if (draw_cnt == 0) draw_finished = 1'b1;
      end

      // both clients toggle their datapath requests regardless of grant
      upd_start_dp        = 1'($urandom_range(0, 1));
      upd_instruction_dp  = IW'($urandom);
      draw_start_dp       = 1'($urandom_range(0, 1));
      draw_instruction_dp = IW'($urandom);

      prev_sdp = sdp_now;
      prev_fin = finished;
    end
  end

  // driver tasks
  task automatic apply_reset_tail();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_frame(input bit ce, input bit poke);
    bit done;
    bit found;
    @(negedge clock);
    start = 1'b1;
    clear_en = ce;
    push_frame(ce);
    @(posedge clock);
    #2;
    check("accept_finished", finished, 1'b0);
    if (ce) check("accept_clr_start_dp", start_dp, 1'b1);
    else    check("accept_upd_start", upd_start, 1'b1);
    start = 1'b0;
    if (poke) begin
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
        @(posedge clock);
        #2;
        if (draw_start && id == MEM_ADDR_WIDTH'(1)) found = 1'b1;
      end
      check("poke_draw_id1_seen", found, 1'b1);
      if (found) begin
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        clear_en = $urandom_range(0, 1);
        @(posedge clock);
        #2;
        start = 1'b0;
      end
    end
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(posedge clock);
      #2;
      if (finished) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: finished still %0b after 4000 cycles", finished);
      reset = 1'b1;
      exp_q.delete();
      model_frames = 0;
      apply_reset_tail();
    end else begin
      repeat (2) @(posedge clock);
      #2;
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("idle_finished", finished, 1'b1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2;
    check("rst_finished", finished, 1'b1);
    check("rst_frame_count", frame_count, 16'd0);
    check("rst_id", id, '0);
    check("rst_upd_start", upd_start, 1'b0);
    check("rst_draw_start", draw_start, 1'b0);
    check("rst_start_dp", start_dp, 1'b0);
    check("rst_instruction_dp", instruction_dp, '0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Reset asserted mid-cycle while waiting on the datapath for pixel (0,0).
    @(negedge clock);
    start = 1'b1;
    clear_en = 1'b1;
    push_frame(1'b1);
    @(posedge clock);
    #2;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    exp_q.delete();
    model_frames = 0;
    #1;
    check("mid_rst_finished", finished, 1'b1);
    check("mid_rst_frame_count", frame_count, 16'd0);
    check("mid_rst_id", id, '0);
    check("mid_rst_start_dp", start_dp, 1'b0);
    check("mid_rst_instruction_dp", instruction_dp, '0);
    check("mid_rst_upd_start", upd_start, 1'b0);
    check("mid_rst_draw_start", draw_start, 1'b0);
    apply_reset_tail();
    repeat (3) @(posedge clock);
    #2;
    check("post_rst_idle_finished", finished, 1'b1);
    check("post_rst_frame_count", frame_count, 16'd0);

    run_frame(1'b1, 1'b0);   // full frame with clear
    run_frame(1'b0, 1'b0);   // no clear
    run_frame(1'b1, 1'b1);   // start pulsed during DRAW_WAIT of id 1
    for (int n = 0; n < 4; n++) run_frame(1'($urandom_range(0, 1)), 1'b0);

    // frame counter wrap
    @(negedge clock);
    force u_dut.frame_count = 16'hffff;
    @(negedge clock);
    release u_dut.frame_count;
    model_frames = 65535;
    run_frame(1'($urandom_range(0, 1)), 1'b0);
    check("wrap_frame_count", frame_count, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
